// File: rtl/data_mem_sized.sv
// -----------------------------------------------------------------------------
// data_mem_sized
//
// Data memory for the load/store unit. It handles RISC-V sized accesses
// (byte/half/word) with per-byte write enables, and sign or zero extension of
// loads. Misaligned and out-of-range accesses are reported and leave memory
// untouched. Requests and responses use valid/ready handshakes. The access
// latency is programmable, so slower RAM can be modelled.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   LATENCY     : cycles from request acceptance to rsp_valid (>= 1)
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   req_valid     : request present
//   req_ready     : block can accept a request (only in IDLE)
//   req_we        : 1 = store, 0 = load
//   req_size      : 0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned  : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr      : byte address
//   req_wdata     : store data, right-aligned
//   rsp_valid     : response present
//   rsp_ready     : consumer accepts the response
//   rsp_rdata     : extended load data; 0 for stores and errors
//   rsp_err       : access faulted, no memory state was changed
// -----------------------------------------------------------------------------
module data_mem_sized #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Shift the selected lane down first, then extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] sh,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            SZ_BYTE: return {{24{~uns & sh[7]}},  sh[7:0]};
            SZ_HALF: return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      lane_q, lane_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [AW-1:0]   req_idx;
    logic [1:0]      req_lane;
    logic            req_err;
    logic            accept;
    logic            wr_en;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic            enter_resp;

    logic [AW-1:0]   cur_idx;
    logic [1:0]      cur_lane;
    logic [1:0]      cur_size;
    logic            cur_uns;
    logic            cur_we;
    logic            cur_err;
    logic [31:0]     rd_shift;
    logic [31:0]     load_data;

    // ------------------------------------------------------------------
    // Request decode and error check (evaluated at acceptance)
    // ------------------------------------------------------------------
    assign req_idx  = req_addr[AW+1:2];
    assign req_lane = req_addr[1:0];
    assign accept   = (state_q == ST_IDLE) && req_valid;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        // Any address bit above the word index means the access is past the end.
        if (|req_addr[31:AW+2]) req_err = 1'b1;
    end

    // Store lanes: the data is shifted up into the lanes that the size and address select.
    always_comb begin
        wr_be = 4'b0000;
        case (req_size)
            SZ_BYTE: wr_be = 4'b0001 << req_lane;
            SZ_HALF: wr_be = 4'b0011 << req_lane;
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    assign wr_data = req_wdata << {req_lane, 3'b000};
    // Gate with rst_n: the FSM sits in IDLE during reset and must not commit.
    assign wr_en   = accept && req_we && !req_err && rst_n;

    // NOTE: the memory array has no reset; contents survive rst_n and only
    // the control flops are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path. In IDLE (LATENCY=1 case) the live request is read directly;
    // otherwise the latched request is used. The word is sampled on the
    // edge entering RESP, so earlier stores are visible.
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_idx  = req_idx;
            cur_lane = req_lane;
            cur_size = req_size;
            cur_uns  = req_unsigned;
            cur_we   = req_we;
            cur_err  = req_err;
        end else begin
            cur_idx  = idx_q;
            cur_lane = lane_q;
            cur_size = size_q;
            cur_uns  = uns_q;
            cur_we   = we_q;
            cur_err  = err_q;
        end
        rd_shift  = mem[cur_idx] >> {cur_lane, 3'b000};
        load_data = (cur_we || cur_err) ? 32'h0 : extend_load(rd_shift, cur_size, cur_uns);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = rsp_err_q;
    end

    // ------------------------------------------------------------------
    // Latched request fields and registered response
    // ------------------------------------------------------------------
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    always_comb begin
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        lane_d    = lane_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        if (accept) begin
            we_d   = req_we;
            size_d = req_size;
            uns_d  = req_unsigned;
            lane_d = req_lane;
            idx_d  = req_idx;
            err_d  = req_err;
        end
        if (enter_resp) begin
            rdata_d   = load_data;
            rsp_err_d = cur_err;
        end
        // Clear the response when it is consumed, so stale data never lingers.
        if ((state_q == ST_RESP) && rsp_ready) begin
            rdata_d   = 32'h0;
            rsp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            lane_q    <= 2'd0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            lane_q    <= lane_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// -----------------------------------------------------------------------------
// tb_data_mem_sized
//
// Bench for data_mem_sized. It drives two instances, one with LATENCY=1
// (index 0) and one with LATENCY=4 (index 1). Expected responses are queued
// when a request is driven and are compared when the DUT responds.
// -----------------------------------------------------------------------------
module tb_data_mem_sized;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    data_mem_sized #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_sized #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input logic obs, input logic exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int s, input string tag);
        chk1(req_ready[s], 1'b1, {tag, " req_ready"});
        chk1(rsp_valid[s], 1'b0, {tag, " rsp_valid"});
        chk32(rsp_rdata[s], 32'h0, {tag, " rsp_rdata"});
        chk1(rsp_err[s], 1'b0, {tag, " rsp_err"});
    endtask

    // One complete access on instance s. Called just after a falling edge.
    // hold   : cycles rsp_ready stays low once rsp_valid is seen
    // early  : rsp_ready held high from request time (no effect before RESP)
    // intrude: during the hold, present a store SW 0xDEADBEEF @0x50 that must
    //          wait until the response is consumed
    task automatic issue(input int s, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int hold, input bit early, input bit intrude, input string tag);
        exp_t e;
        int   lat;
        sb.push_back('{tag, exp_rdata, exp_err});
        req_valid[s]    = 1'b1;
        req_we[s]       = we;
        req_size[s]     = size;
        req_unsigned[s] = uns;
        req_addr[s]     = addr;
        req_wdata[s]    = wdata;
        rsp_ready[s]    = early;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields; the pending access must not see them.
        req_valid[s]    = 1'b0;
        req_we[s]       = 1'($urandom);
        req_size[s]     = 2'($urandom);
        req_unsigned[s] = 1'($urandom);
        req_addr[s]     = $urandom;
        req_wdata[s]    = $urandom;
        lat = 1;
        while (!rsp_valid[s] && lat < 32) begin
            chk1(req_ready[s], 1'b0, {tag, " req_ready in wait"});
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk32(32'(lat), 32'((s == 1) ? LAT1 : LAT0), {e.tag, " latency"});
        chk32(rsp_rdata[s], e.rdata, {e.tag, " rdata"});
        chk1(rsp_err[s], e.err, {e.tag, " err"});
        chk1(req_ready[s], 1'b0, {e.tag, " req_ready in resp"});
        if (intrude) begin
            req_valid[s]    = 1'b1;
            req_we[s]       = 1'b1;
            req_size[s]     = 2'd2;
            req_unsigned[s] = 1'b0;
            req_addr[s]     = 32'h50;
            req_wdata[s]    = 32'hDEAD_BEEF;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1(rsp_valid[s], 1'b1, {e.tag, " valid held"});
            chk32(rsp_rdata[s], e.rdata, {e.tag, " rdata held"});
            chk1(req_ready[s], 1'b0, {e.tag, " req_ready held"});
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        chk1(rsp_valid[s], 1'b0, {e.tag, " valid drop"});
        chk1(req_ready[s], 1'b1, {e.tag, " ready back"});
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s]    = 1'b0;
            req_we[s]       = 1'b0;
            req_size[s]     = 2'd0;
            req_unsigned[s] = 1'b0;
            req_addr[s]     = 32'h0;
            req_wdata[s]    = 32'h0;
            rsp_ready[s]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs(0, "reset l1");
        chk_reset_outputs(1, "reset l4");
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- LATENCY=1: word and sized loads -----------------
        issue(0, 1, 2'd2, 0, 32'h10, 32'h8000_00FF, 32'h0, 0, 0, 0, 0, "SW 0x10");
        issue(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h8000_00FF, 0, 0, 0, 0, "LW 0x10");
        issue(0, 0, 2'd0, 0, 32'h10, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, "LB 0x10");
        issue(0, 0, 2'd0, 1, 32'h10, 32'h0, 32'h0000_00FF, 0, 0, 0, 0, "LBU 0x10");
        issue(0, 0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFF_8000, 0, 0, 0, 0, "LH 0x12");
        issue(0, 0, 2'd1, 1, 32'h12, 32'h0, 32'h0000_8000, 0, 0, 0, 0, "LHU 0x12");
        issue(0, 0, 2'd2, 1, 32'h10, 32'h0, 32'h8000_00FF, 0, 0, 0, 0, "LW uns ignored");

        // ---------------- byte / half stores ------------------------------
        issue(0, 1, 2'd2, 0, 32'h20, 32'h1122_3344, 32'h0, 0, 0, 0, 0, "SW 0x20");
        issue(0, 1, 2'd0, 0, 32'h21, 32'h1234_56AA, 32'h0, 0, 0, 0, 0, "SB 0x21");
        issue(0, 1, 2'd1, 0, 32'h22, 32'h5555_BEEF, 32'h0, 0, 0, 0, 0, "SH 0x22");
        issue(0, 0, 2'd2, 0, 32'h20, 32'h0, 32'hBEEF_AA44, 0, 0, 0, 0, "LW 0x20");
        issue(0, 0, 2'd0, 0, 32'h23, 32'h0, 32'hFFFF_FFBE, 0, 0, 0, 0, "LB 0x23");
        issue(0, 0, 2'd0, 1, 32'h21, 32'h0, 32'h0000_00AA, 0, 0, 0, 0, "LBU 0x21");

        // ---------------- error cases -------------------------------------
        issue(0, 1, 2'd2, 0, 32'h30, 32'h1234_5678, 32'h0, 0, 0, 0, 0, "SW 0x30");
        issue(0, 1, 2'd1, 0, 32'h31, 32'h0000_FFFF, 32'h0, 1, 0, 0, 0, "SH 0x31 misaligned");
        issue(0, 0, 2'd2, 0, 32'h30, 32'h0, 32'h1234_5678, 0, 0, 0, 0, "LW 0x30 unchanged");
        issue(0, 0, 2'd2, 0, 32'h32, 32'h0, 32'h0, 1, 0, 0, 0, "LW 0x32 misaligned");
        issue(0, 0, 2'd1, 0, 32'h33, 32'h0, 32'h0, 1, 0, 0, 0, "LH 0x33 misaligned");
        issue(0, 0, 2'd3, 0, 32'h30, 32'h0, 32'h0, 1, 0, 0, 0, "size3 load");
        issue(0, 1, 2'd3, 0, 32'h30, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, "size3 store");
        issue(0, 0, 2'd2, 0, 32'h30, 32'h0, 32'h1234_5678, 0, 0, 0, 0, "LW 0x30 after size3");
        issue(0, 1, 2'd2, 0, 32'h00, 32'hA5A5_A5A5, 32'h0, 0, 0, 0, 0, "SW 0x0");
        issue(0, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1, 0, 0, 0, "LW 0x400 range");
        issue(0, 1, 2'd2, 0, 32'h400, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, "SW 0x400 range");
        issue(0, 1, 2'd0, 0, 32'h3FF, 32'h0000_0077, 32'h0, 0, 0, 0, 0, "SB 0x3FF last");
        issue(0, 0, 2'd2, 0, 32'h00, 32'h0, 32'hA5A5_A5A5, 0, 0, 0, 0, "LW 0x0 unchanged");
        issue(0, 0, 2'd0, 1, 32'h3FF, 32'h0, 32'h0000_0077, 0, 0, 0, 0, "LBU 0x3FF");

        // ---------------- LATENCY=4: latency and backpressure -------------
        issue(1, 1, 2'd2, 0, 32'h50, 32'h1111_1111, 32'h0, 0, 0, 0, 0, "L4 SW 0x50");
        issue(1, 0, 2'd2, 0, 32'h50, 32'h0, 32'h1111_1111, 0, 3, 0, 1, "L4 LW 0x50 held");
        issue(1, 1, 2'd2, 0, 32'h50, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, "L4 SW 0x50 late");
        issue(1, 0, 2'd2, 0, 32'h50, 32'h0, 32'hDEAD_BEEF, 0, 0, 1, 0, "L4 LW 0x50 early ready");
        issue(1, 0, 2'd0, 1, 32'h53, 32'h0, 32'h0000_00DE, 0, 0, 0, 0, "L4 LBU 0x53");
        issue(1, 0, 2'd1, 0, 32'h52, 32'h0, 32'hFFFF_DEAD, 0, 0, 0, 0, "L4 LH 0x52");

        // ---------------- reset mid-operation, LATENCY=4 ------------------
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = 2'd2;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk1(req_ready[1], 1'b0, "midop busy before reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(1, "midop reset l4");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs(1, "after release l4");
        issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, "L4 LW 0x40 after reset");

        // ---------------- reset while a load response is held, LATENCY=1 --
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_size[0]  = 2'd2;
        req_addr[0]  = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk1(rsp_valid[0], 1'b1, "resp before reset valid");
        chk32(rsp_rdata[0], 32'h8000_00FF, "resp before reset rdata");
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0, "reset in resp l1");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 0, 2'd1, 1, 32'h10, 32'h0, 32'h0000_00FF, 0, 0, 0, 0, "LHU 0x10 after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
